// File: rtl/calc2_port_driver.sv
// ---------------------------------------------------------------------------
// calc2_port_driver
//
// Drives one request port of calc2_top and tracks its responses. Whole
// commands (cmd, op1, op2) arrive over a valid/ready handshake and leave as
// the two-beat calc2 request (beat 1: cmd/op1/tag, beat 2: cmd=0/op2/tag)
// under a locally allocated 2-bit tag. Returning responses are matched
// against the allocated tags and turned into exactly one completion per
// issued command; a per-tag watchdog retires commands that are never
// answered with a timeout completion (resp=3, data=0).
//
// Ports
//   c_clk, reset         clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready      upstream command handshake
//   s_cmd, s_op1, s_op2  upstream command and operands
//   req_cmd_in           calc2 request command (0 = no command)
//   req_data_in          calc2 request data (op1 on beat 1, op2 on beat 2)
//   req_tag_in           calc2 request tag
//   out_resp/data/tag    calc2 response (out_resp==0 means no response)
//   rsp_valid            one-cycle completion strobe
//   rsp_resp/data/tag    completion: 1 ok, 2 overflow/invalid, 3 timeout
//   outstanding          number of allocated tags (0..4)
//   err_spurious         sticky flag: response seen on an unallocated tag
// ---------------------------------------------------------------------------
module calc2_port_driver #(
  parameter int DW      = 32,
  parameter int CW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_cmd,
  input  logic [DW-1:0] s_op1,
  input  logic [DW-1:0] s_op2,
  output logic [CW-1:0] req_cmd_in,
  output logic [DW-1:0] req_data_in,
  output logic [1:0]    req_tag_in,
  input  logic [1:0]    out_resp,
  input  logic [DW-1:0] out_data,
  input  logic [1:0]    out_tag,
  output logic          rsp_valid,
  output logic [1:0]    rsp_resp,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    rsp_tag,
  output logic [2:0]    outstanding,
  output logic          err_spurious
);

  // Watchdog counters count up to TIMEOUT and saturate there.
  localparam int              CNTW     = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(TIMEOUT);
  localparam logic [1:0]      RESP_NONE    = 2'd0;
  localparam logic [1:0]      RESP_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_t;

  // Number of set bits in a 4-bit mask.
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    popcount4 = {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  state_t          state;
  logic [3:0]      alloc_mask;
  logic [CNTW-1:0] cnt [4];
  logic [DW-1:0]   op2_hold;

  logic            has_free;
  logic            port_open;
  logic            accept;
  logic            issue;
  logic [1:0]      new_tag;
  logic            resp_seen;
  logic            resp_hit;
  logic            resp_spur;
  logic [3:0]      expired;
  logic            any_expired;
  logic [1:0]      exp_tag;
  logic            done;
  logic [1:0]      done_tag;
  logic [1:0]      done_resp;
  logic [DW-1:0]   done_data;
  logic [3:0]      free_bits;
  logic [3:0]      set_bits;
  logic [3:0]      alloc_next;

  // Upstream handshake and tag allocation from the registered state and mask.
  // s_ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    has_free  = (alloc_mask != 4'b1111);
    port_open = (state == IDLE) || (state == BEAT2);
    s_ready   = reset && port_open && has_free;
    accept    = s_valid && s_ready;
    // cmd==0 is consumed by the handshake but never issued.
    issue     = accept && (s_cmd != {CW{1'b0}});
    new_tag   = lowest_set(~alloc_mask);
  end

  // Response classification and watchdog expiry detection.
  always_comb begin
    resp_seen = (out_resp != RESP_NONE);
    resp_hit  = resp_seen && alloc_mask[out_tag];
    resp_spur = resp_seen && !alloc_mask[out_tag];
    // A counter at TIMEOUT-1 reaches TIMEOUT on this edge; one already at
    // TIMEOUT lost a previous arbitration and is still waiting.
    for (int i = 0; i < 4; i++) begin
      expired[i] = alloc_mask[i] && (cnt[i] >= CNT_LAST);
    end
    any_expired = |expired;
    exp_tag     = lowest_set(expired);
  end

  // One completion per cycle: a DUT response beats any expiry, then lowest
  // expired tag first.
  always_comb begin
    if (resp_hit) begin
      done      = 1'b1;
      done_tag  = out_tag;
      done_resp = out_resp;
      done_data = out_data;
    end else if (any_expired) begin
      done      = 1'b1;
      done_tag  = exp_tag;
      done_resp = RESP_TIMEOUT;
      done_data = {DW{1'b0}};
    end else begin
      done      = 1'b0;
      done_tag  = 2'd0;
      done_resp = RESP_NONE;
      done_data = {DW{1'b0}};
    end
  end

  // Next allocation mask. The set and freed bits never overlap: allocation
  // only picks tags free in the registered mask, freeing only hits allocated
  // ones, so a tag freed this cycle is allocatable only from the next one.
  always_comb begin
    if (done) begin
      free_bits = 4'b0001 << done_tag;
    end else begin
      free_bits = 4'b0000;
    end
    if (issue) begin
      set_bits = 4'b0001 << new_tag;
    end else begin
      set_bits = 4'b0000;
    end
    alloc_next = (alloc_mask & ~free_bits) | set_bits;
  end

  // Issue FSM with registered request outputs.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_cmd_in  <= {CW{1'b0}};
      req_data_in <= {DW{1'b0}};
      req_tag_in  <= 2'd0;
      op2_hold    <= {DW{1'b0}};
    end else begin
      case (state)
        IDLE, BEAT2: begin
          if (issue) begin
            state       <= BEAT1;
            req_cmd_in  <= s_cmd;
            req_data_in <= s_op1;
            req_tag_in  <= new_tag;
            op2_hold    <= s_op2;
          end else begin
            state       <= IDLE;
            req_cmd_in  <= {CW{1'b0}};
            req_data_in <= {DW{1'b0}};
            req_tag_in  <= 2'd0;
            op2_hold    <= op2_hold;
          end
        end
        BEAT1: begin
          state       <= BEAT2;
          req_cmd_in  <= {CW{1'b0}};
          req_data_in <= op2_hold;
          req_tag_in  <= req_tag_in;
          op2_hold    <= op2_hold;
        end
        default: begin
          state       <= IDLE;
          req_cmd_in  <= {CW{1'b0}};
          req_data_in <= {DW{1'b0}};
          req_tag_in  <= 2'd0;
          op2_hold    <= {DW{1'b0}};
        end
      endcase
    end
  end

  // Allocation mask, completion outputs, occupancy and spurious flag.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      alloc_mask   <= 4'b0000;
      outstanding  <= 3'd0;
      rsp_valid    <= 1'b0;
      rsp_resp     <= RESP_NONE;
      rsp_data     <= {DW{1'b0}};
      rsp_tag      <= 2'd0;
      err_spurious <= 1'b0;
    end else begin
      alloc_mask   <= alloc_next;
      outstanding  <= popcount4(alloc_next);
      rsp_valid    <= done;
      rsp_resp     <= done_resp;
      rsp_data     <= done_data;
      rsp_tag      <= done_tag;
      err_spurious <= err_spurious || resp_spur;
    end
  end

  // Per-tag watchdog: cleared on allocate/free, counts while allocated,
  // saturates at TIMEOUT so an expiry that loses arbitration is kept.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= {CNTW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (set_bits[i] || free_bits[i]) begin
          cnt[i] <= {CNTW{1'b0}};
        end else if (alloc_mask[i] && (cnt[i] != CNT_SAT)) begin
          cnt[i] <= cnt[i] + CNTW'(1);
        end else begin
          cnt[i] <= cnt[i];
        end
      end
    end
  end

endmodule
